// File: rtl/fp_mult_collector.sv
// fp_mult_collector: result collector placed directly downstream of the FP multiplier.
// A {valid, tag} shadow pipeline tracks each issued multiply. Results are captured
// into a first-word-fall-through FIFO. A credit counter throttles issue so that the
// non-stallable multiplier can never overrun the FIFO.
// Optional feature macro: FP_MULT_FLAGS_EN stores {nan, inf, zero} flags per result.
// When it is undefined, out_flags is tied to zero.

`ifndef FP_MULT_LATENCY
`define FP_MULT_LATENCY 4
`endif

// Checker: pushing into a full result FIFO is a fatal error.
module fp_mult_collector_chk #(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic [CW-1:0] count
);
  // Overflow guard: the credit scheme must make this unreachable.
  assert property (@(posedge clk) disable iff (!rst) !(push && (count == CW'(FIFO_DEPTH))))
    else $fatal(1, "fp_mult_collector: push into full result FIFO");
endmodule

module fp_mult_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int LATENCY    = `FP_MULT_LATENCY,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              issue_valid,
  input  logic [TAG_WIDTH-1:0]              issue_tag,
  output logic                              issue_ready,
  output logic                              mult_enable,
  input  logic [DATA_WIDTH-1:0]             mult_res,
  output logic                              out_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [TAG_WIDTH-1:0]              out_tag,
  output logic [2:0]                        out_flags,
  input  logic                              out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy,
  output logic                              busy
);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EXP_W = (DATA_WIDTH == 64) ? 11 : ((DATA_WIDTH == 16) ? 5 : 8);
  localparam int MAN_W = DATA_WIDTH - 1 - EXP_W;

  logic [LATENCY-1:0]    sh_valid_r;
  logic [TAG_WIDTH-1:0]  sh_tag_r [LATENCY];
  logic [DATA_WIDTH-1:0] data_mem_r [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  tag_mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         occ_r;
  logic [CW-1:0]         count_r;
  logic                  issue_s;
  logic                  push_s;
  logic                  pop_s;

  // Pointer advance with wrap at FIFO_DEPTH (depth need not be a power of two).
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : (p + PW'(1));
  endfunction

  // Credits come from the registered occupancy only, so a same-cycle pop does not bypass.
  assign issue_ready = (occ_r < CW'(FIFO_DEPTH));
  assign issue_s     = issue_valid & issue_ready;
  assign mult_enable = issue_s;
  assign push_s      = sh_valid_r[LATENCY-1];
  assign out_valid   = (count_r != {CW{1'b0}});
  assign pop_s       = out_valid & out_ready;
  assign occupancy   = occ_r;
  assign busy        = (occ_r != {CW{1'b0}});
  assign out_data    = data_mem_r[rd_ptr_r];
  assign out_tag     = tag_mem_r[rd_ptr_r];

  // Shadow valids shift every cycle. Reset drops in-flight results so they are never pushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_valid_r <= {LATENCY{1'b0}};
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) sh_valid_r[i] <= sh_valid_r[i-1];
      sh_valid_r[0] <= issue_s;
    end
  end

  // Shadow tags follow the valids. Tags are only meaningful where the matching valid is set.
  always_ff @(posedge clk) begin
    for (int i = LATENCY - 1; i > 0; i--) sh_tag_r[i] <= sh_tag_r[i-1];
    sh_tag_r[0] <= issue_tag;
  end

  // FIFO pointers and entry count. The count drives out_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Credit counter: in-flight plus buffered results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_r <= {CW{1'b0}};
    end else begin
      case ({issue_s, pop_s})
        2'b10:   occ_r <= occ_r + CW'(1);
        2'b01:   occ_r <= occ_r - CW'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Capture the multiplier result and its tag when the last shadow stage is valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_r[wr_ptr_r] <= mult_res;
      tag_mem_r[wr_ptr_r]  <= sh_tag_r[LATENCY-1];
    end
  end

`ifdef FP_MULT_FLAGS_EN
  logic [2:0] flag_mem_r [FIFO_DEPTH];

  // Classify an IEEE value as {nan, inf, zero}. The sign bit is ignored.
  function automatic logic [2:0] calc_flags(input logic [DATA_WIDTH-1:0] r);
    logic exp_ones;
    logic exp_zero;
    logic man_zero;
    exp_ones = &r[DATA_WIDTH-2 -: EXP_W];
    exp_zero = ~|r[DATA_WIDTH-2 -: EXP_W];
    man_zero = ~|r[MAN_W-1:0];
    return {exp_ones & ~man_zero, exp_ones & man_zero, exp_zero & man_zero};
  endfunction

  // Store the flags alongside the captured data.
  always_ff @(posedge clk) begin
    if (push_s) flag_mem_r[wr_ptr_r] <= calc_flags(mult_res);
  end

  assign out_flags = flag_mem_r[rd_ptr_r];
`else
  assign out_flags = 3'b000;
`endif

  fp_mult_collector_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CW(CW)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .count (count_r)
  );
endmodule

// File: tb/tb_fp_mult_collector.sv
// Self-checking bench for fp_mult_collector (LATENCY=4, FIFO_DEPTH=4).
// The bench acts as the multiplier. It keeps an in-order queue of issued operations:
// each entry holds its due cycle (issue + 4) and becomes visible one cycle later.
module tb_fp_mult_collector;
  localparam int LAT = 4;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic [5:0]  issue_tag = 6'd0;
  logic        issue_ready;
  logic        mult_enable;
  logic [31:0] mult_res = 32'd0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [5:0]  out_tag;
  logic [2:0]  out_flags;
  logic        out_ready = 1'b0;
  logic [2:0]  occupancy;
  logic        busy;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] data;
    int          due;
  } op_t;

  op_t q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  int  acc_cnt = 0;

  fp_mult_collector #(.DATA_WIDTH(32), .TAG_WIDTH(6), .LATENCY(LAT), .FIFO_DEPTH(DEP)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_tag   (issue_tag),
    .issue_ready (issue_ready),
    .mult_enable (mult_enable),
    .mult_res    (mult_res),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .out_flags   (out_flags),
    .out_ready   (out_ready),
    .occupancy   (occupancy),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Cycle index, advanced on each active edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, obs, exp);
  endtask

  function automatic logic [2:0] ref_flags(input logic [31:0] r);
`ifdef FP_MULT_FLAGS_EN
    int e;
    int m;
    e = int'(r[30:23]);
    m = int'(r[22:0]);
    return {(e == 255) && (m != 0), (e == 255) && (m == 0), (e == 0) && (m == 0)};
`else
    return 3'b000;
`endif
  endfunction

  // One clock cycle: drive inputs, check against the model, then advance the model.
  task automatic run_cycle(input logic iv, input logic [5:0] tg, input logic [31:0] d,
                           input logic ordy);
    int  exp_occ;
    bit  exp_rdy;
    bit  exp_en;
    bit  exp_vld;
    @(negedge clk);
    issue_valid = iv;
    issue_tag   = tg;
    out_ready   = ordy;
    mult_res    = $urandom;
    foreach (q[i]) if (q[i].due == cyc) mult_res = q[i].data;
    #1;
    exp_occ = q.size();
    exp_rdy = (exp_occ < DEP);
    exp_en  = iv && exp_rdy;
    exp_vld = (q.size() > 0) && (q[0].due < cyc);
    check_val("occupancy",   32'(occupancy),   32'(exp_occ));
    check_val("busy",        32'(busy),        32'(exp_occ != 0));
    check_val("issue_ready", 32'(issue_ready), 32'(exp_rdy));
    check_val("mult_enable", 32'(mult_enable), 32'(exp_en));
    check_val("out_valid",   32'(out_valid),   32'(exp_vld));
    if (exp_vld) begin
      check_val("out_data",  out_data,         q[0].data);
      check_val("out_tag",   32'(out_tag),     32'(q[0].tag));
      check_val("out_flags", 32'(out_flags),   32'(ref_flags(q[0].data)));
    end
    if (mult_enable) acc_cnt++;
    if (exp_vld && ordy) void'(q.pop_front());
    if (exp_en) q.push_back('{tag: tg, data: d, due: cyc + LAT});
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 6'd0, 32'd0, ordy);
  endtask

  // One-cycle reset pulse with idle inputs; reset values are checked while it is held.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    issue_valid = 1'b0;
    out_ready = 1'b0;
    mult_res = $urandom;
    q.delete();
    #1;
    check_val("rst_occupancy",   32'(occupancy),   32'd0);
    check_val("rst_out_valid",   32'(out_valid),   32'd0);
    check_val("rst_busy",        32'(busy),        32'd0);
    check_val("rst_mult_enable", 32'(mult_enable), 32'd0);
    check_val("rst_issue_ready", 32'(issue_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] specials [6];
    specials[0] = 32'h7FC00000;
    specials[1] = 32'hFF800000;
    specials[2] = 32'h80000000;
    specials[3] = 32'h00000000;
    specials[4] = 32'h7F800001;
    specials[5] = 32'h3F800000;

    do_reset();
    idle(3, 1'b1);

    // Single op.
    run_cycle(1'b1, 6'd5, 32'h40C00000, 1'b1);
    idle(7, 1'b1);

    // Back-to-back.
    for (int i = 1; i <= 4; i++) run_cycle(1'b1, 6'(i), $urandom, 1'b1);
    idle(8, 1'b1);

    // Backpressure: six requests, only four accepted.
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 6'(10 + i), $urandom, 1'b0);
    check_val("accepted", 32'(acc_cnt), 32'd4);
    idle(4, 1'b0);
    idle(1, 1'b1);
    run_cycle(1'b1, 6'd20, $urandom, 1'b0);
    idle(12, 1'b1);

    // Reset mid-flight.
    run_cycle(1'b1, 6'd7, $urandom, 1'b1);
    run_cycle(1'b1, 6'd8, $urandom, 1'b1);
    do_reset();
    idle(10, 1'b1);

    // Flags.
    run_cycle(1'b1, 6'd30, 32'h7FC00000, 1'b1);
    run_cycle(1'b1, 6'd31, 32'hFF800000, 1'b1);
    run_cycle(1'b1, 6'd32, 32'h80000000, 1'b1);
    idle(8, 1'b1);

    // Simultaneous push and pop at occupancy 2.
    run_cycle(1'b1, 6'd40, $urandom, 1'b0);
    run_cycle(1'b1, 6'd41, $urandom, 1'b0);
    idle(3, 1'b0);
    run_cycle(1'b1, 6'd42, $urandom, 1'b1);
    idle(8, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      run_cycle(1'($urandom_range(0, 3) != 0), 6'($urandom), d, 1'($urandom_range(0, 2) != 0));
    end
    idle(12, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
